// File: rtl/ssp_rx_deser.sv
// SSP receive deserializer.
// Oversamples an asynchronous serial clock/frame/data interface in the PCLK
// domain, assembles DATA_W-bit words framed by SSPFSSIN, and parks completed
// words in a small circular holding buffer that drains into a downstream FIFO.
module ssp_rx_deser #(
  parameter int DATA_W     = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int HOLD_DEPTH = 2
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic              enable,
  input  logic              SSPCLKIN,
  input  logic              SSPFSSIN,
  input  logic              SSPRXD,
  input  logic              rx_fifo_full,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] RxData,
  output logic              write_fifo,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(HOLD_DEPTH);
  localparam int OCC_W = $clog2(HOLD_DEPTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and serial-clock edge detect
  // ---------------------------------------------------------------------------
  logic [1:0] sclk_sync;
  logic [1:0] fss_sync;
  logic [1:0] rxd_sync;
  logic       sclk_d;
  logic       strobe;
  logic       fss;
  logic       rxd;

  // Two-flop synchronizers plus a third flop on the clock for rise detection
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      sclk_sync <= '0;
      fss_sync  <= '0;
      rxd_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], SSPCLKIN};
      fss_sync  <= {fss_sync[0], SSPFSSIN};
      rxd_sync  <= {rxd_sync[0], SSPRXD};
      sclk_d    <= sclk_sync[1];
    end
  end

  // FSS and RXD travel through identical delay, so they line up with the strobe
  assign strobe = sclk_sync[1] & ~sclk_d;
  assign fss    = fss_sync[1];
  assign rxd    = rxd_sync[1];

  // ---------------------------------------------------------------------------
  // Frame FSM and shift register
  // ---------------------------------------------------------------------------
  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  shift_next;
  logic               last_bit;
  logic               complete;

  // Next shift-register value including the bit on the current strobe, so the
  // completed word can be written straight into the buffer on that cycle
  generate
    if (LSB_FIRST) begin : g_lsb
      assign shift_next = {rxd, shreg[DATA_W-1:1]};
    end else begin : g_msb
      assign shift_next = {shreg[DATA_W-2:0], rxd};
    end
  endgenerate

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  // Dropping enable wins over a completing strobe: the word is abandoned
  assign complete = (state == SHIFT) && enable && strobe && last_bit;

  // Framing: wait for FSS on a strobe, then collect DATA_W bits per word
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe && fss && enable) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (!enable) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (strobe) begin
            shreg <= shift_next;
            if (last_bit) begin
              bit_cnt <= '0;
              // FSS on the final bit chains straight into the next word
              if (!fss) state <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT);

  // ---------------------------------------------------------------------------
  // Holding buffer
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [HOLD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [DATA_W-1:0] last_q;
  logic              buf_full;
  logic              pop;
  logic              push;
  logic              drop;

  assign buf_full = (occ == OCC_W'(HOLD_DEPTH));
  assign pop      = (occ != '0) && !rx_fifo_full;
  // A pop in the same cycle frees the slot, so a full buffer still accepts
  assign push     = complete && (!buf_full || pop);
  assign drop     = complete && buf_full && !pop;

  assign write_fifo = pop;
  assign RxData     = (occ != '0) ? mem[rd_ptr] : last_q;

  // Word storage; contents only matter where occupancy says they are valid
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= shift_next;
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Remember the last head word so RxData holds steady once the buffer drains
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) last_q <= '0;
    else if (pop) last_q <= mem[rd_ptr];
  end

  // Sticky overrun; a new drop outranks a clear in the same cycle
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B)         overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_ssp_rx_deser.sv
// Bench for ssp_rx_deser: an 8-bit MSB-first instance and a 12-bit LSB-first
// instance share the serial pins; each is enabled only for its own traffic.
module tb_ssp_rx_deser;

  logic PCLK = 1'b0;
  logic CLEAR_B;
  logic en8, en12;
  logic SSPCLKIN, SSPFSSIN, SSPRXD;
  logic rx_fifo_full, clr_overrun;
  logic [7:0]  rx8;
  logic [11:0] rx12;
  logic wf8, ov8, busy8, wf12, ov12, busy12;

  int checks = 0;
  int errors = 0;
  int pulses8 = 0;
  int pulses12 = 0;
  logic [15:0] got8[$];
  logic [15:0] got12[$];
  logic [15:0] exp8[$];
  logic [15:0] exp12[$];

  always #5 PCLK = ~PCLK;

  ssp_rx_deser #(.DATA_W(8), .LSB_FIRST(1'b0), .HOLD_DEPTH(2)) dut8 (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B), .enable(en8), .SSPCLKIN(SSPCLKIN),
    .SSPFSSIN(SSPFSSIN), .SSPRXD(SSPRXD), .rx_fifo_full(rx_fifo_full),
    .clr_overrun(clr_overrun), .RxData(rx8), .write_fifo(wf8),
    .overrun(ov8), .busy(busy8));

  ssp_rx_deser #(.DATA_W(12), .LSB_FIRST(1'b1), .HOLD_DEPTH(2)) dut12 (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B), .enable(en12), .SSPCLKIN(SSPCLKIN),
    .SSPFSSIN(SSPFSSIN), .SSPRXD(SSPRXD), .rx_fifo_full(rx_fifo_full),
    .clr_overrun(clr_overrun), .RxData(rx12), .write_fifo(wf12),
    .overrun(ov12), .busy(busy12));

  // Record every word pushed downstream
  always @(negedge PCLK) begin
    if (wf8) begin
      got8.push_back(16'(rx8));
      pulses8++;
    end
    if (wf12) begin
      got12.push_back(16'(rx12));
      pulses12++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
    #1;
  endtask

  // One serial bit: data/FSS set with the clock low, rising edge mid-bit
  task automatic send_bit(input bit f, input bit d);
    @(negedge PCLK);
    SSPFSSIN = f;
    SSPRXD   = d;
    SSPCLKIN = 1'b0;
    repeat (4) @(negedge PCLK);
    SSPCLKIN = 1'b1;
    repeat (4) @(negedge PCLK);
  endtask

  // seq[0] is the first bit on the wire
  task automatic send_frame(input logic [15:0] seq, input int n, input bit start,
                            input bit fss_hold, input bit last_fss);
    if (start) send_bit(1'b1, 1'b0);
    for (int i = 0; i < n; i++)
      send_bit((i == n - 1) ? last_fss : fss_hold, seq[i]);
  endtask

  // Reference: word value from the wire order and the bit-order rule
  function automatic logic [15:0] model_word(input logic [15:0] seq, input int n, input bit lsb);
    int w = 0;
    for (int i = 0; i < n; i++)
      if (seq[i]) w += lsb ? (1 << i) : (1 << (n - 1 - i));
    return 16'(w);
  endfunction

  // Wire order for sending a word MSB first
  function automatic logic [15:0] msb_seq(input logic [15:0] word, input int n);
    logic [15:0] s = '0;
    for (int i = 0; i < n; i++) s[i] = word[n - 1 - i];
    return s;
  endfunction

  initial begin
    logic [15:0] seq;
    int base, p0;
    bit b2b, start;

    CLEAR_B = 1'b0; en8 = 1'b0; en12 = 1'b0;
    SSPCLKIN = 1'b0; SSPFSSIN = 1'b0; SSPRXD = 1'b0;
    rx_fifo_full = 1'b0; clr_overrun = 1'b0;
    tick(2);
    check("reset_wf", wf8, 0);
    check("reset_ov", ov8, 0);
    check("reset_busy", busy8, 0);
    check("reset_rx8", rx8, 0);
    check("reset_rx12", rx12, 0);
    CLEAR_B = 1'b1;
    tick(2);

    // 0xA5 MSB first, with exact latency on the final bit
    en8 = 1'b1;
    seq = msb_seq(16'hA5, 8);
    send_bit(1'b1, 1'b0);
    check("a5_busy_start", busy8, 1);
    for (int i = 0; i < 7; i++) send_bit(1'b0, seq[i]);
    @(negedge PCLK);
    SSPFSSIN = 1'b0; SSPRXD = seq[7]; SSPCLKIN = 1'b0;
    repeat (4) @(negedge PCLK);
    SSPCLKIN = 1'b1;
    tick(2);
    check("a5_wf_strobe_cycle", wf8, 0);
    tick(1);
    check("a5_wf", wf8, 1);
    check("a5_data", rx8, 8'hA5);
    check("a5_busy_end", busy8, 0);
    tick(1);
    check("a5_wf_single", wf8, 0);
    tick(4);
    check("a5_pulses", pulses8, 1);
    check("a5_rx_hold", rx8, 8'hA5);

    // 12-bit LSB first
    en8 = 1'b0; en12 = 1'b1;
    seq = 16'h0C01;
    send_frame(seq, 12, 1'b1, 1'b0, 1'b0);
    tick(4);
    check("lsb12_pulses", pulses12, 1);
    check("lsb12_data", got12[$], 12'hC01);
    check("lsb12_model", model_word(seq, 12, 1'b1), 12'hC01);
    check("lsb12_busy", busy12, 0);
    en12 = 1'b0;

    // Back-to-back frames with FSS held high
    en8 = 1'b1;
    base = got8.size();
    send_frame(msb_seq(16'h3C, 8), 8, 1'b1, 1'b1, 1'b1);
    tick(1);
    check("b2b_busy_between", busy8, 1);
    send_frame(msb_seq(16'hF0, 8), 8, 1'b0, 1'b1, 1'b0);
    tick(3);
    check("b2b_count", got8.size() - base, 2);
    check("b2b_first", got8[base], 8'h3C);
    check("b2b_second", got8[base + 1], 8'hF0);
    check("b2b_busy_end", busy8, 0);

    // Overrun with downstream full
    rx_fifo_full = 1'b1;
    p0 = pulses8;
    send_frame(msb_seq(16'h11, 8), 8, 1'b1, 1'b0, 1'b0);
    send_frame(msb_seq(16'h22, 8), 8, 1'b1, 1'b0, 1'b0);
    tick(2);
    check("full_no_ov_at_depth", ov8, 0);
    check("full_head", rx8, 8'h11);
    send_frame(msb_seq(16'h33, 8), 8, 1'b1, 1'b0, 1'b0);
    tick(2);
    check("full_ov_set", ov8, 1);
    check("full_no_wf", wf8, 0);
    @(posedge PCLK); #2 rx_fifo_full = 1'b0;
    tick(1);
    check("drain_wf0", wf8, 1);
    check("drain_d0", rx8, 8'h11);
    tick(1);
    check("drain_wf1", wf8, 1);
    check("drain_d1", rx8, 8'h22);
    tick(1);
    check("drain_wf_end", wf8, 0);
    check("drain_pulses", pulses8 - p0, 2);
    check("drain_ov_sticky", ov8, 1);
    @(posedge PCLK); #2 clr_overrun = 1'b1;
    @(posedge PCLK); #2 clr_overrun = 1'b0;
    tick(1);
    check("ov_cleared", ov8, 0);
    tick(20);
    check("dropped_never_sent", pulses8 - p0, 2);

    // Enable drop mid-frame
    p0 = pulses8;
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    tick(1);
    check("endrop_busy_before", busy8, 1);
    en8 = 1'b0;
    tick(1);
    check("endrop_busy_after", busy8, 0);
    tick(20);
    check("endrop_no_push", pulses8 - p0, 0);
    en8 = 1'b1;
    send_frame(msb_seq(16'h5A, 8), 8, 1'b1, 1'b0, 1'b0);
    tick(3);
    check("endrop_next_count", pulses8 - p0, 1);
    check("endrop_next_data", got8[$], 8'h5A);

    // Reset mid-frame with one word buffered
    rx_fifo_full = 1'b1;
    p0 = pulses8;
    send_frame(msb_seq(16'h77, 8), 8, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
    tick(1);
    check("rst_pre_busy", busy8, 1);
    check("rst_pre_head", rx8, 8'h77);
    #2 CLEAR_B = 1'b0;
    #1;
    check("rst_busy", busy8, 0);
    check("rst_wf", wf8, 0);
    check("rst_ov", ov8, 0);
    check("rst_rx", rx8, 0);
    tick(3);
    CLEAR_B = 1'b1;
    rx_fifo_full = 1'b0;
    tick(10);
    check("rst_word_gone", pulses8 - p0, 0);
    send_frame(msb_seq(16'hC3, 8), 8, 1'b0, 1'b0, 1'b0);
    tick(3);
    check("rst_needs_fss", pulses8 - p0, 0);
    check("rst_needs_fss_busy", busy8, 0);
    send_frame(msb_seq(16'hC3, 8), 8, 1'b1, 1'b0, 1'b0);
    tick(3);
    check("rst_after_count", pulses8 - p0, 1);
    check("rst_after_data", got8[$], 8'hC3);

    // Randomized frames against the reference model
    base = got8.size();
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      seq = 16'($urandom_range(0, 255));
      b2b = (k < 19) && ($urandom_range(0, 1) == 1);
      exp8.push_back(model_word(seq, 8, 1'b0));
      send_frame(seq, 8, start, 1'($urandom_range(0, 1)), b2b);
      start = !b2b;
    end
    tick(4);
    check("rand8_count", got8.size() - base, exp8.size());
    for (int k = 0; k < exp8.size() && base + k < got8.size(); k++)
      check($sformatf("rand8_word%0d", k), got8[base + k], exp8[k]);

    en8 = 1'b0; en12 = 1'b1;
    base = got12.size();
    for (int k = 0; k < 6; k++) begin
      seq = 16'($urandom_range(0, 4095));
      exp12.push_back(model_word(seq, 12, 1'b1));
      send_frame(seq, 12, 1'b1, 1'b0, 1'b0);
    end
    tick(4);
    check("rand12_count", got12.size() - base, exp12.size());
    for (int k = 0; k < exp12.size() && base + k < got12.size(); k++)
      check($sformatf("rand12_word%0d", k), got12[base + k], exp12[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssp_rx_deser.md
SSP_RX_DESER -- requirements
Module: ssp_rx_deser

Interface
REQ-001 The block SHALL have these parameters, one per line:
- DATA_W, 8, serial word width in bits, legal range 4..16.
- LSB_FIRST, 0, bit order: 0 = MSB first, 1 = LSB first.
- HOLD_DEPTH, 2, word holding buffer depth, power of 2, legal range 2..8.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- PCLK  in  1  sole clock; all state is on the rising edge.
- CLEAR_B  in  1  asynchronous active-low reset.
- enable  in  1  receiver enable.
- SSPCLKIN  in  1  serial clock, asynchronous, at most PCLK/4.
- SSPFSSIN  in  1  frame sync, asynchronous.
- SSPRXD  in  1  serial data, asynchronous.
- rx_fifo_full  in  1  downstream FIFO full.
- clr_overrun  in  1  clears the sticky overrun flag.
- RxData  out  DATA_W  head word of the holding buffer.
- write_fifo  out  1  one-PCLK push strobe to the downstream FIFO.
- overrun  out  1  sticky flag: a word was dropped.
- busy  out  1  frame in progress.

Function
REQ-003 SSPCLKIN, SSPFSSIN and SSPRXD SHALL each pass through a 2-flop synchronizer.
REQ-004 A sample strobe SHALL fire for exactly one PCLK cycle on each rising edge of synchronized SSPCLKIN (edge detect on a third flop).
- Synchronized FSS and RXD SHALL be sampled on that strobe cycle.
REQ-005 The FSM SHALL have two states: IDLE and SHIFT.
REQ-006 IDLE -> SHIFT SHALL occur on a strobe with FSS=1 and enable=1, with bit count cleared to 0.
- The first data bit SHALL be taken on the next strobe.
REQ-007 In SHIFT, each strobe SHALL capture RXD into the shift register and increment the bit count.
- Bit count width SHALL be clog2(DATA_W).
- LSB_FIRST=0: shift left, with the first bit landing in bit DATA_W-1 of the finished word.
- LSB_FIRST=1: shift right, with the first bit landing in bit 0.
REQ-008 On the strobe capturing bit DATA_W-1 the word SHALL be complete: it SHALL be pushed to the holding buffer (including that final bit) and the bit count SHALL wrap to 0.
- If FSS=1 on that strobe, the FSM SHALL stay in SHIFT (back-to-back frame, no gap bit).
- Otherwise the FSM SHALL return to IDLE.
REQ-009 FSS changes on strobes other than the final bit SHALL be ignored while in SHIFT.
REQ-010 If enable drops while in SHIFT, the FSM SHALL go to IDLE on the next PCLK, the partial word SHALL be discarded, and nothing SHALL be pushed.
REQ-011 The holding buffer SHALL be a circular FIFO of HOLD_DEPTH words.
- Read and write pointers SHALL wrap modulo HOLD_DEPTH.
- An occupancy counter SHALL run from 0 to HOLD_DEPTH.
REQ-012 write_fifo SHALL equal (occupancy != 0) AND NOT rx_fifo_full.
- RxData SHALL equal the head word whenever occupancy != 0, and SHALL hold its last value otherwise.
- The head SHALL pop on every cycle where write_fifo=1.
REQ-013 Latency SHALL be 1 PCLK: write_fifo is asserted, at the earliest, the cycle after the completion strobe.
- Successive words SHALL pop on consecutive cycles while rx_fifo_full=0.
REQ-014 If a push and a pop occur in the same cycle, occupancy SHALL be unchanged. This applies when full: the push SHALL be accepted and overrun SHALL NOT set.
REQ-015 A completion with occupancy==HOLD_DEPTH and no same-cycle pop SHALL drop the new word and set overrun.
REQ-016 overrun SHALL stay set until a cycle with clr_overrun=1.
- If clr_overrun coincides with a new drop, overrun SHALL remain 1 (set wins).
REQ-017 busy SHALL be 1 exactly while the FSM is in SHIFT.

Reset
REQ-018 When CLEAR_B=0, the block SHALL asynchronously force the following, regardless of PCLK:
- FSM = IDLE, bit count = 0, pointers and occupancy = 0.
- Synchronizer and edge-detect flops = 0.
- write_fifo = 0, overrun = 0, busy = 0, RxData = 0.
REQ-019 Reset asserted mid-frame SHALL discard the partial word and all buffered words.
- After release, the block SHALL need a fresh FSS before accepting data.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- DATA_W=8, MSB first: send FSS then 0xA5 -> exactly one write_fifo pulse with RxData=0xA5, 1 PCLK after the 8th strobe; busy then 0.
- LSB_FIRST=1, DATA_W=12, bits sent 1,0,0,0,0,0,0,0,0,0,1,1 -> RxData=0xC01.
- Back-to-back: FSS held high, send 0x3C then 0xF0 with no gap -> two pushes, 0x3C then 0xF0, and busy stays 1 between them.
- rx_fifo_full=1, HOLD_DEPTH=2: send 0x11, 0x22, 0x33 -> overrun=1 and 0x33 dropped; release full -> pops 0x11 then 0x22 on consecutive cycles; clr_overrun -> overrun=0.
- enable drops after 4 bits of 0xFF -> busy=0 next cycle and no push; the next full frame 0x5A is received correctly.
- CLEAR_B pulsed low mid-frame with 1 word buffered -> outputs at reset values immediately, and the buffered word is never emitted.
